// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - bus bundle between host/DMA requesters, the arbiter and the SRAM data port
//
// Carries both requester channels (i_h_* / o_h_*, i_d_* / o_d_*) and the SRAM-side
// data port (o_address, o_data, o_wmask, o_wren, o_rden, i_data_out, o_busy).
// Signal directions are named from the arbiter's point of view:
//   slave  : arbiter view (i_* in, o_* out)
//   master : environment view (drives i_*, observes o_*)
interface sram_port_arbiter_if #(
    parameter int IF_W     = 128,
    parameter int IF_ADR_W = 32
);
    logic                i_h_req;
    logic                o_h_gnt;
    logic [IF_ADR_W-1:0] i_h_addr;
    logic                i_h_wren;
    logic [IF_W-1:0]     i_h_wdata;
    logic [IF_W-1:0]     i_h_wmask;
    logic                o_h_rvalid;
    logic [IF_W-1:0]     o_h_rdata;

    logic                i_d_req;
    logic                o_d_gnt;
    logic [IF_ADR_W-1:0] i_d_addr;
    logic                i_d_wren;
    logic [IF_W-1:0]     i_d_wdata;
    logic [IF_W-1:0]     i_d_wmask;
    logic                o_d_rvalid;
    logic [IF_W-1:0]     o_d_rdata;

    logic [IF_ADR_W-1:0] o_address;
    logic [IF_W-1:0]     o_data;
    logic [IF_W-1:0]     o_wmask;
    logic                o_wren;
    logic                o_rden;
    logic [IF_W-1:0]     i_data_out;
    logic                o_busy;

    modport slave (
        input  i_h_req, i_h_addr, i_h_wren, i_h_wdata, i_h_wmask,
        output o_h_gnt, o_h_rvalid, o_h_rdata,
        input  i_d_req, i_d_addr, i_d_wren, i_d_wdata, i_d_wmask,
        output o_d_gnt, o_d_rvalid, o_d_rdata,
        output o_address, o_data, o_wmask, o_wren, o_rden, o_busy,
        input  i_data_out
    );

    modport master (
        output i_h_req, i_h_addr, i_h_wren, i_h_wdata, i_h_wmask,
        input  o_h_gnt, o_h_rvalid, o_h_rdata,
        output i_d_req, i_d_addr, i_d_wren, i_d_wdata, i_d_wmask,
        input  o_d_gnt, o_d_rvalid, o_d_rdata,
        input  o_address, o_data, o_wmask, o_wren, o_rden, o_busy,
        output i_data_out
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin host/DMA arbiter for the shared SRAM data port
//
// Shares one SRAM data port between the host path and the DMA/prefetch engine.
// The winning access is registered onto the SRAM port one cycle after grant, and
// a READ_LATENCY-deep tag pipe routes each read's data back to its issuer.
//
// Ports:
//   i_clk  : clock, all logic on the rising edge
//   i_rst  : synchronous active-high reset
//   bus    : sram_port_arbiter_if.slave
//            host  channel  i_h_req/o_h_gnt/i_h_addr/i_h_wren/i_h_wdata/i_h_wmask/o_h_rvalid/o_h_rdata
//            DMA   channel  i_d_* / o_d_* (same set)
//            SRAM  port     o_address/o_data/o_wmask/o_wren/o_rden (registered), i_data_out, o_busy
//
// Build option: SRAM_ARB_HOST_PRIO_EN selects fixed host priority instead of
// round-robin with a BURST_Q grant quantum.
module sram_port_arbiter #(
    parameter int IF_W         = 128,
    parameter int IF_ADR_W     = 32,
    parameter int READ_LATENCY = 2,
    parameter int BURST_Q      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    sram_port_arbiter_if.slave    bus
);

    localparam int                BCNT_W   = $clog2(BURST_Q + 1);
    localparam logic [BCNT_W-1:0] BCNT_MAX = BCNT_W'(BURST_Q);
    localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_H = 2'd1,
        ST_OWN_D = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [BCNT_W-1:0]         r_bcnt;
    logic [BCNT_W-1:0]         w_bcnt_nxt;
    logic                      w_h_gnt;
    logic                      w_d_gnt;
    logic                      w_own_is_d;
    logic                      w_own_req;
    logic                      w_oth_req;

    logic                      w_acc;
    logic [IF_ADR_W-1:0]       w_sel_addr;
    logic [IF_W-1:0]           w_sel_wdata;
    logic [IF_W-1:0]           w_sel_wmask;
    logic                      w_sel_wren;

    logic [IF_ADR_W-1:0]       r_address;
    logic [IF_W-1:0]           r_data;
    logic [IF_W-1:0]           r_wmask;
    logic                      r_wren;
    logic                      r_rden;
    logic                      r_rd_d;

    // Tag pipe: stage 0 is loaded from the strobe cycle, the last stage lines up
    // with the cycle the SRAM presents read data.
    logic [READ_LATENCY-1:0]   r_tag_v;
    logic [READ_LATENCY-1:0]   r_tag_d;

    // Owner-relative view of the requests; an unused state encoding behaves as host-owned.
    assign w_own_is_d = (r_state == ST_OWN_D);
    assign w_own_req  = w_own_is_d ? bus.i_d_req : bus.i_h_req;
    assign w_oth_req  = w_own_is_d ? bus.i_h_req : bus.i_d_req;

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
        w_h_gnt     = 1'b0;
        w_d_gnt     = 1'b0;
        if (!i_rst) begin
`ifdef SRAM_ARB_HOST_PRIO_EN
            w_bcnt_nxt = '0;
            if (bus.i_h_req) begin
                w_h_gnt     = 1'b1;
                w_state_nxt = ST_OWN_H;
            end else if (bus.i_d_req) begin
                w_d_gnt     = 1'b1;
                w_state_nxt = ST_OWN_D;
            end else begin
                w_state_nxt = ST_IDLE;
            end
`else
            if (!bus.i_h_req && !bus.i_d_req) begin
                w_state_nxt = ST_IDLE;
                w_bcnt_nxt  = '0;
            end else if (r_state == ST_IDLE) begin
                // Fresh arbitration: host wins a tie.
                w_h_gnt     = bus.i_h_req;
                w_d_gnt     = !bus.i_h_req;
                w_state_nxt = bus.i_h_req ? ST_OWN_H : ST_OWN_D;
                w_bcnt_nxt  = BCNT_ONE;
            end else if (w_own_req && (!w_oth_req || r_bcnt < BCNT_MAX)) begin
                // Owner keeps the port; count saturates so an uncontended owner
                // must yield on the first cycle the other side shows up.
                w_h_gnt = !w_own_is_d;
                w_d_gnt = w_own_is_d;
                if (r_bcnt != BCNT_MAX) begin
                    w_bcnt_nxt = r_bcnt + BCNT_ONE;
                end
            end else begin
                w_h_gnt     = w_own_is_d;
                w_d_gnt     = !w_own_is_d;
                w_state_nxt = w_own_is_d ? ST_OWN_H : ST_OWN_D;
                w_bcnt_nxt  = BCNT_ONE;
            end
`endif
        end
    end

    assign w_acc       = w_h_gnt | w_d_gnt;
    assign w_sel_addr  = w_d_gnt ? bus.i_d_addr  : bus.i_h_addr;
    assign w_sel_wdata = w_d_gnt ? bus.i_d_wdata : bus.i_h_wdata;
    assign w_sel_wmask = w_d_gnt ? bus.i_d_wmask : bus.i_h_wmask;
    assign w_sel_wren  = w_d_gnt ? bus.i_d_wren  : bus.i_h_wren;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_bcnt    <= '0;
            r_address <= '0;
            r_data    <= '0;
            r_wmask   <= '0;
            r_wren    <= 1'b0;
            r_rden    <= 1'b0;
            r_rd_d    <= 1'b0;
            r_tag_v   <= '0;
            r_tag_d   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_wren  <= w_acc & w_sel_wren;
            r_rden  <= w_acc & ~w_sel_wren;
            r_rd_d  <= w_d_gnt;
            // Address/data/mask hold their last value on idle cycles.
            if (w_acc) begin
                r_address <= w_sel_addr;
                r_data    <= w_sel_wdata;
                r_wmask   <= w_sel_wmask;
            end
            r_tag_v[0] <= r_rden;
            r_tag_d[0] <= r_rd_d;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_d[i] <= r_tag_d[i-1];
            end
        end
    end

    assign bus.o_h_gnt    = w_h_gnt;
    assign bus.o_d_gnt    = w_d_gnt;
    assign bus.o_address  = r_address;
    assign bus.o_data     = r_data;
    assign bus.o_wmask    = r_wmask;
    assign bus.o_wren     = r_wren;
    assign bus.o_rden     = r_rden;
    assign bus.o_h_rvalid = r_tag_v[READ_LATENCY-1] & ~r_tag_d[READ_LATENCY-1];
    assign bus.o_d_rvalid = r_tag_v[READ_LATENCY-1] &  r_tag_d[READ_LATENCY-1];
    assign bus.o_h_rdata  = bus.i_data_out;
    assign bus.o_d_rdata  = bus.i_data_out;
    assign bus.o_busy     = r_wren | r_rden | (|r_tag_v);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;
    localparam int IF_W     = 128;
    localparam int IF_ADR_W = 32;
    localparam int RL       = 2;
    localparam int BQ       = 4;

    typedef logic [IF_W-1:0]     data_t;
    typedef logic [IF_ADR_W-1:0] addr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.IF_W(IF_W), .IF_ADR_W(IF_ADR_W)) bus ();

    sram_port_arbiter #(
        .IF_W(IF_W), .IF_ADR_W(IF_ADR_W), .READ_LATENCY(RL), .BURST_Q(BQ)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input data_t got, input data_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: SRAM contents, per-cycle grant history, scheduled read returns.
    data_t mem [addr_t];
    int    hist[$];          // 0 none, 1 host, 2 DMA, one entry per cycle
    data_t rv_data[int];     // keyed by the cycle the data must come back
    int    rv_own [int];
    int    cyc    = 0;
    int    last_g = 0;
    logic  e_wren = 1'b0, e_rden = 1'b0;
    addr_t e_addr = '0;
    data_t e_data = '0, e_mask = '0;

    function automatic data_t mem_rd(input addr_t a);
        if (mem.exists(a)) return mem[a];
        return {a, ~a, a, ~a};
    endfunction

    // Grant rule from the arbitration policy: a lone requester wins; under contention
    // the current owner keeps the port until it has had BQ consecutive grants.
    function automatic int expect_grant(input logic h, input logic d);
        int last, run;
        if (!h && !d) return 0;
`ifdef SRAM_ARB_HOST_PRIO_EN
        return h ? 1 : 2;
`else
        if (!d) return 1;
        if (!h) return 2;
        if (hist.size() == 0 || hist[$] == 0) return 1;
        last = hist[$];
        run  = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == last && run < BQ; i--) run++;
        return (run < BQ) ? last : 3 - last;
`endif
    endfunction

    function automatic addr_t rnd_addr();
        return addr_t'($urandom_range(15) << 4);
    endfunction

    function automatic data_t rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic data_t rnd_mask();
        case ($urandom_range(2))
            0:       return '1;
            1:       return '0;
            default: return rnd_data();
        endcase
    endfunction

    // New request only when the previous one was accepted (or none was pending).
    task automatic gen(input int ph, input int pd, input int pw);
        if (!bus.i_h_req || last_g == 1) begin
            bus.i_h_req   = ($urandom_range(99) < ph);
            bus.i_h_addr  = rnd_addr();
            bus.i_h_wren  = ($urandom_range(99) < pw);
            bus.i_h_wdata = rnd_data();
            bus.i_h_wmask = rnd_mask();
        end
        if (!bus.i_d_req || last_g == 2) begin
            bus.i_d_req   = ($urandom_range(99) < pd);
            bus.i_d_addr  = rnd_addr();
            bus.i_d_wren  = ($urandom_range(99) < pw);
            bus.i_d_wdata = rnd_data();
            bus.i_d_wmask = rnd_mask();
        end
    endtask

    // Called at the falling edge with requests already set for this cycle.
    task automatic run_cycle(input logic r, output int obs);
        int    g;
        logic  eh, ed, eb;
        addr_t a;
        data_t wd, wm;
        logic  wr;
        rst = r;
        bus.i_data_out = rv_own.exists(cyc) ? rv_data[cyc] : rnd_data();
        #1;
        g = r ? 0 : expect_grant(bus.i_h_req, bus.i_d_req);
        obs = bus.o_h_gnt ? 1 : (bus.o_d_gnt ? 2 : 0);
        check("h_gnt", data_t'(bus.o_h_gnt), data_t'(g == 1));
        check("d_gnt", data_t'(bus.o_d_gnt), data_t'(g == 2));
        check("wren",  data_t'(bus.o_wren),  data_t'(e_wren));
        check("rden",  data_t'(bus.o_rden),  data_t'(e_rden));
        check("addr",  data_t'(bus.o_address), data_t'(e_addr));
        check("wdata", bus.o_data,  e_data);
        check("wmask", bus.o_wmask, e_mask);
        eh = rv_own.exists(cyc) && rv_own[cyc] == 1;
        ed = rv_own.exists(cyc) && rv_own[cyc] == 2;
        check("h_rvalid", data_t'(bus.o_h_rvalid), data_t'(eh));
        check("d_rvalid", data_t'(bus.o_d_rvalid), data_t'(ed));
        if (eh) check("h_rdata", bus.o_h_rdata, rv_data[cyc]);
        if (ed) check("d_rdata", bus.o_d_rdata, rv_data[cyc]);
        eb = e_wren | e_rden;
        for (int k = cyc; k < cyc + RL; k++) if (rv_own.exists(k)) eb = 1'b1;
        check("busy", data_t'(bus.o_busy), data_t'(eb));

        if (r) begin
            for (int k = cyc + 1; k <= cyc + RL + 1; k++) begin
                rv_own.delete(k);
                rv_data.delete(k);
            end
            e_wren = 1'b0; e_rden = 1'b0;
            e_addr = '0; e_data = '0; e_mask = '0;
            hist.push_back(0);
        end else begin
            hist.push_back(g);
            e_wren = 1'b0; e_rden = 1'b0;
            if (g != 0) begin
                a  = (g == 1) ? bus.i_h_addr  : bus.i_d_addr;
                wd = (g == 1) ? bus.i_h_wdata : bus.i_d_wdata;
                wm = (g == 1) ? bus.i_h_wmask : bus.i_d_wmask;
                wr = (g == 1) ? bus.i_h_wren  : bus.i_d_wren;
                e_addr = a; e_data = wd; e_mask = wm;
                if (wr) begin
                    e_wren = 1'b1;
                    mem[a] = (mem_rd(a) & ~wm) | (wd & wm);
                end else begin
                    e_rden = 1'b1;
                    rv_data[cyc + 1 + RL] = mem_rd(a);
                    rv_own [cyc + 1 + RL] = g;
                end
            end
        end
        last_g = g;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        int o;
        int ng;
        rst = 1'b1;
        bus.i_h_req = 0; bus.i_h_addr = '0; bus.i_h_wren = 0; bus.i_h_wdata = '0; bus.i_h_wmask = '0;
        bus.i_d_req = 0; bus.i_d_addr = '0; bus.i_d_wren = 0; bus.i_d_wdata = '0; bus.i_d_wmask = '0;
        bus.i_data_out = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset held three checked cycles, then idle.
        for (int i = 0; i < 3; i++) run_cycle(1'b1, o);
        for (int i = 0; i < 2; i++) run_cycle(1'b0, o);

        // Single host read at 0x40 returning 0xDEAD.
        mem[addr_t'(32'h40)] = data_t'(32'hDEAD);
        bus.i_h_req = 1; bus.i_h_addr = 32'h40; bus.i_h_wren = 0;
        run_cycle(1'b0, o);
        bus.i_h_req = 0;
        for (int i = 0; i < RL + 2; i++) run_cycle(1'b0, o);

        // Continuous contention from IDLE, all reads: H x BQ, D x BQ, ...
        ng = 0;
        for (int i = 0; i < 4 * BQ; i++) begin
            gen(100, 100, 0);
            run_cycle(1'b0, o);
`ifdef SRAM_ARB_HOST_PRIO_EN
            check("rr_pattern", data_t'(o), data_t'(1));
`else
            check("rr_pattern", data_t'(o), data_t'(((ng / BQ) % 2 == 0) ? 1 : 2));
`endif
            ng++;
        end
        for (int i = 0; i < 4 * BQ + RL + 2; i++) begin
            gen(0, 0, 0);
            run_cycle(1'b0, o);
        end

        // Host write 0x1234 to 0x10, then DMA read of 0x10.
        bus.i_h_req = 1; bus.i_h_addr = 32'h10; bus.i_h_wren = 1;
        bus.i_h_wdata = data_t'(32'h1234); bus.i_h_wmask = '1;
        run_cycle(1'b0, o);
        bus.i_h_req = 0;
        bus.i_d_req = 1; bus.i_d_addr = 32'h10; bus.i_d_wren = 0;
        run_cycle(1'b0, o);
        bus.i_d_req = 0;
        for (int i = 0; i < RL + 2; i++) run_cycle(1'b0, o);

        // Two reads, reset one cycle after the second strobe.
        bus.i_h_req = 1; bus.i_h_addr = 32'h20; bus.i_h_wren = 0;
        run_cycle(1'b0, o);
        bus.i_h_addr = 32'h30;
        run_cycle(1'b0, o);
        bus.i_h_req = 0;
        run_cycle(1'b0, o);
        run_cycle(1'b1, o);
        for (int i = 0; i < RL + 2; i++) run_cycle(1'b0, o);

        // Both requesting for 10 cycles, then host drops.
        for (int i = 0; i < 10; i++) begin
            gen(100, 100, 30);
            run_cycle(1'b0, o);
        end
        for (int i = 0; i < 12; i++) begin
            gen(0, 100, 30);
            run_cycle(1'b0, o);
        end

        // Random traffic with varying load and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            gen((i / 250) % 2 == 0 ? 80 : 40, (i / 125) % 2 == 0 ? 85 : 30, 35);
            run_cycle(($urandom_range(199) == 0), o);
        end
        for (int i = 0; i < BQ * 4 + RL + 4; i++) begin
            gen(0, 0, 0);
            run_cycle(1'b0, o);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-requester arbiter that shares the single data-side port of the double-buffered SRAM system (address/data/mask/wren/rden, fixed read latency) between the host path (output of the AXI4 data bridge) and an internal DMA/prefetch engine. It sits between those two masters and the SRAM top's data interface. It registers the winning access onto the SRAM port and tracks in-flight reads so each read's data returns to the requester that issued it. Arbitration is round-robin with a per-owner burst quantum.

## Interface

- IF_W, 128, data width of the SRAM data port (bits)
- IF_ADR_W, 32, address width
- READ_LATENCY, 2, SRAM port read latency: cycles from strobe to valid i_data_out (≥1)
- BURST_Q, 4, maximum consecutive grants to one owner while the other is waiting (≥1)

- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_h_req  in  1  host request valid
- o_h_gnt  out  1  host request accepted this cycle (combinational)
- i_h_addr  in  IF_ADR_W  host address
- i_h_wren  in  1  1 = write, 0 = read
- i_h_wdata  in  IF_W  host write data
- i_h_wmask  in  IF_W  host per-bit write mask
- o_h_rvalid  out  1  host read data valid
- o_h_rdata  out  IF_W  host read data
- i_d_req, o_d_gnt, i_d_addr, i_d_wren, i_d_wdata, i_d_wmask, o_d_rvalid, o_d_rdata: the same set of signals, with the same widths, for the DMA requester
- o_address  out  IF_ADR_W  SRAM port address (registered)
- o_data  out  IF_W  SRAM write data (registered)
- o_wmask  out  IF_W  SRAM write mask (registered)
- o_wren  out  1  SRAM write strobe (registered)
- o_rden  out  1  SRAM read strobe (registered)
- i_data_out  in  IF_W  SRAM read data
- o_busy  out  1  any read in flight or strobe active

## Operation

- Request handshake:
  - A requester holds req and all fields stable until gnt.
  - A transfer occurs when req && gnt.
  - At most one grant per cycle.
- Arbitration state: IDLE, OWN_H, OWN_D, plus a burst counter bcnt (0..BURST_Q).
- IDLE:
  - Grant the single requester; if both request, host wins.
  - Move to OWN_x with bcnt=1.
- OWN_x, owner requesting, and (other not requesting or bcnt<BURST_Q):
  - Grant the owner.
  - bcnt increments and saturates at BURST_Q.
- OWN_x, other requesting, and (owner not requesting or bcnt==BURST_Q):
  - Grant the other.
  - Move to OWN_other with bcnt=1.
- No request in a cycle: go to IDLE.
- Accepted access: next cycle drives o_address/o_data/o_wmask and exactly one of o_wren/o_rden. Otherwise both strobes are 0; address, data and mask hold their last value.
- Read routing:
  - Each read strobe pushes a tag (valid, owner) into a READ_LATENCY-deep shift register.
  - At tag output, the matching o_x_rvalid=1 and o_x_rdata=i_data_out (combinational pass-through).
  - The non-matching rdata also carries i_data_out, qualified by its rvalid=0.
- Writes produce no response.
- Reset values:
  - o_wren, o_rden, o_h_rvalid, o_d_rvalid, o_busy = 0.
  - o_address, o_data, o_wmask = 0.
  - State IDLE, bcnt 0, all tags invalid.
  - Gnt is 0 while i_rst=1.

## Timing

- Request accepted in cycle t → strobe in cycle t+1 → o_x_rvalid in cycle t+1+READ_LATENCY.
- Throughput: one access per cycle, sustained. Back-to-back reads from alternating owners return in issue order with correct tags.
- Grant is combinational from req and registered state; there is no req→gnt→req combinational loop.
- Reset mid-operation: in-flight tags are cleared and no rvalid is produced for reads issued before reset. Requesters must reissue them.
- Simultaneous write by owner and arbitration switch: the write issued at t is committed; the switch affects only the grant at t+1.
- bcnt never exceeds BURST_Q; with BURST_Q=1, strict alternation under contention.

## Configuration

- SRAM_ARB_HOST_PRIO_EN defined:
  - Fixed priority: host is granted whenever i_h_req=1.
  - DMA is granted only in cycles with no host request.
  - BURST_Q and bcnt are unused (bcnt held at 0).
- Undefined: round-robin with burst quantum as described above.

## Test plan

- Reset then idle. Hold i_rst 3 cycles, then deassert. → All strobes/rvalids 0, o_busy 0, gnts 0 during reset.
- Single host read. Host read at addr 0x40, i_data_out=0xDEAD at t+3. → o_rden at t+1, o_h_rvalid=1 with rdata 0xDEAD at t+3, o_d_rvalid stays 0.
- Contention, BURST_Q=4. Both request continuously from IDLE, all reads. → Grant pattern H,H,H,H,D,D,D,D,H…; every rvalid goes to the issuer.
- Interleaved write/read. Host writes 0x1234 to 0x10, mask all-ones; DMA then reads 0x10 with the model returning 0x1234. → o_wren then o_rden on consecutive cycles; only o_d_rvalid fires, data 0x1234.
- Reset mid-flight. Issue 2 reads, assert i_rst one cycle after the second strobe. → No rvalid after reset; state IDLE.
- Macro build, SRAM_ARB_HOST_PRIO_EN. Both requesting for 10 cycles, then host drops. → DMA ungranted for 10 cycles, granted on cycle 11.
